conv_mac_pipe: RTL and testbench

Pipelined, parametrised signed multiply-accumulate engine for the convolution datapath. It generalises the fixed combinational 16×8 signed product to configurable widths and a configurable multiplier pipeline depth. It accumulates a window of `TAPS` products per output and applies round, shift and saturate before emitting one result per window. It sits between the line-buffer/weight fetch stage and the activation/output stage of a conv layer.

---
 rtl/conv_mac_pkg.sv | 68 ++++++
 rtl/conv_mac_mul_pipe.sv | 59 +++++
 rtl/conv_mac_pipe.sv | 139 +++++++++++++
 tb/tb_conv_mac_pipe.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_pkg.sv
// Shared types and helpers for the convolution MAC pipeline: sideband tags,
// width helpers, the round/shift/saturate step and the parameter sanity check.
package conv_mac_pkg;

  // Width of the intermediate arithmetic used by the round/saturate step.
  localparam int CALC_W = 64;

  // Tags that travel alongside each product.
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } side_t;

  // Rounded/saturated value plus saturation flag.
  typedef struct packed {
    logic signed [CALC_W-1:0] val;
    logic                     sat;
  } rss_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Round half up, arithmetic shift, then clamp (sat=1) or pass through
  // for truncation by the caller (sat=0).
  function automatic rss_t round_shift_sat(input logic signed [CALC_W-1:0] s,
                                           input int shift,
                                           input int out_width,
                                           input bit sat);
    logic signed [CALC_W-1:0] r, half, hi, lo;
    rss_t res;
    if (shift > 0) begin
      half = CALC_W'(1) <<< (shift - 1);
      r    = (s + half) >>> shift;
    end else begin
      r = s;
    end
    hi      = (CALC_W'(1) <<< (out_width - 1)) - CALC_W'(1);
    lo      = -(CALC_W'(1) <<< (out_width - 1));
    res.val = r;
    res.sat = 1'b0;
    if (sat) begin
      if (r > hi) begin
        res.val = hi;
        res.sat = 1'b1;
      end else if (r < lo) begin
        res.val = lo;
        res.sat = 1'b1;
      end
    end
    return res;
  endfunction

  // Legal configuration: accumulator can never overflow, output fits in the
  // accumulator, and the rounding add cannot overflow the calc width.
  function automatic bit cfg_ok(input int a_w, input int b_w, input int stages,
                                input int taps, input int acc_w, input int out_w);
    return (stages >= 1) && (taps >= 1) && (out_w >= 1) &&
           (acc_w >= a_w + b_w + clog2(taps)) &&
           (out_w <= acc_w) && (acc_w <= CALC_W - 2);
  endfunction

endpackage

// File: rtl/conv_mac_mul_pipe.sv
// Signed A x B multiplier with NUM_STAGE output registers. Data registers
// carry no reset so the product path maps onto a DSP slice; only the
// valid/first/last sideband is reset and can be flushed.
module conv_mac_mul_pipe
  import conv_mac_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 8,
  parameter int NUM_STAGE = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ce,
  input  logic                              flush,
  input  logic signed [A_WIDTH-1:0]         a,
  input  logic signed [B_WIDTH-1:0]         b,
  input  side_t                             side_in,
  output logic signed [A_WIDTH+B_WIDTH-1:0] p,
  output side_t                             side_out,
  output logic                              any_vld
);

  localparam int P_W = A_WIDTH + B_WIDTH;

  logic signed [P_W-1:0] p_pipe [1:NUM_STAGE];
  side_t [NUM_STAGE:1]   side_pipe;

  // Product shift register, enable only (no reset for DSP inference).
  always_ff @(posedge clk) begin
    if (ce) begin
      p_pipe[1] <= P_W'(a) * P_W'(b);
      for (int i = 2; i <= NUM_STAGE; i++) p_pipe[i] <= p_pipe[i-1];
    end
  end

  // Sideband shift register; flush drops every in-flight tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      side_pipe <= '0;
    end else if (ce) begin
      if (flush) begin
        side_pipe <= '0;
      end else begin
        side_pipe[1] <= side_in;
        for (int i = 2; i <= NUM_STAGE; i++) side_pipe[i] <= side_pipe[i-1];
      end
    end
  end

  // Any product still travelling through the multiplier.
  always_comb begin
    any_vld = 1'b0;
    for (int i = 1; i <= NUM_STAGE; i++) any_vld = any_vld | side_pipe[i].vld;
  end

  assign p        = p_pipe[NUM_STAGE];
  assign side_out = side_pipe[NUM_STAGE];

endmodule

// File: rtl/conv_mac_pipe.sv
// Pipelined signed MAC for the conv datapath: tags each accepted tap with its
// window position, multiplies, accumulates TAPS products and emits one
// rounded/shifted/saturated result per window.
// Pipeline: input reg -> NUM_STAGE mul regs -> acc/capture -> output reg.
module conv_mac_pipe
  import conv_mac_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 8,
  parameter int NUM_STAGE = 3,
  parameter int TAPS      = 9,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 24,
  parameter int SHIFT     = 0,
  parameter int SAT       = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ce,
  input  logic                        in_valid,
  input  logic signed [A_WIDTH-1:0]   in_a,
  input  logic signed [B_WIDTH-1:0]   in_b,
  input  logic                        restart,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat,
  output logic                        busy
);

  localparam int TAP_W = (TAPS > 1) ? clog2(TAPS) : 1;
  localparam int P_W   = A_WIDTH + B_WIDTH;

  if (!cfg_ok(A_WIDTH, B_WIDTH, NUM_STAGE, TAPS, ACC_WIDTH, OUT_WIDTH)) begin : g_bad_cfg
    $error("conv_mac_pipe: illegal parameter combination");
  end

  logic [TAP_W-1:0]         tap_idx, cur_idx;
  logic signed [A_WIDTH-1:0] a_r;
  logic signed [B_WIDTH-1:0] b_r;
  side_t                    in_side, m_side;
  logic signed [P_W-1:0]    p;
  logic                     m_any;
  logic signed [ACC_WIDTH-1:0] acc, acc_next, s_r;
  logic                     s_vld;
  rss_t                     rss;
  logic                     unused_hi;

  // Position of a tap accepted this cycle; restart forces a fresh window.
  always_comb begin
    cur_idx = restart ? '0 : tap_idx;
  end

  // Tap counter and input-stage sideband tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_idx <= '0;
      in_side <= '0;
    end else if (ce) begin
      in_side.vld   <= in_valid;
      in_side.first <= (cur_idx == '0);
      in_side.last  <= (cur_idx == TAP_W'(TAPS - 1));
      if (in_valid)
        tap_idx <= (cur_idx == TAP_W'(TAPS - 1)) ? '0 : cur_idx + TAP_W'(1);
      else
        tap_idx <= cur_idx;
    end
  end

  // Input operand registers (DSP A/B registers, no reset).
  always_ff @(posedge clk) begin
    if (ce && in_valid) begin
      a_r <= in_a;
      b_r <= in_b;
    end
  end

  conv_mac_mul_pipe #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .NUM_STAGE(NUM_STAGE)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .flush   (restart),
    .a       (a_r),
    .b       (b_r),
    .side_in (in_side),
    .p       (p),
    .side_out(m_side),
    .any_vld (m_any)
  );

  // Next accumulator value: a first-tagged product starts a new window.
  always_comb begin
    acc_next = m_side.first ? ACC_WIDTH'(p) : acc + ACC_WIDTH'(p);
  end

  // Accumulator and end-of-window capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      s_r   <= '0;
      s_vld <= 1'b0;
    end else if (ce) begin
      if (m_side.vld && !restart) acc <= acc_next;
      s_vld <= m_side.vld && m_side.last && !restart;
      if (m_side.vld && m_side.last) s_r <= acc_next;
    end
  end

  // Round, shift and saturate the captured window sum.
  always_comb begin
    rss = round_shift_sat(CALC_W'(s_r), SHIFT, OUT_WIDTH, SAT != 0);
  end

  assign unused_hi = ^rss.val[CALC_W-1:OUT_WIDTH];

  // Output register; data and flag hold between result pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (ce) begin
      out_valid <= s_vld && !restart;
      if (s_vld && !restart) begin
        out_data <= rss.val[OUT_WIDTH-1:0];
        out_sat  <= rss.sat;
      end
    end
  end

  // Anything partially accumulated or still in flight.
  always_comb begin
    busy = (tap_idx != '0) | in_side.vld | m_any | s_vld;
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed bench for conv_mac_pipe: basic window, stall, restart, reset,
// saturation/truncation and rounding, with hand-computed expectations.
module tb_conv_mac_pipe;

  logic clk = 1'b0;
  logic reset, ce, restart;
  logic v3, v9, v1;
  logic signed [15:0] in_a;
  logic signed [7:0]  in_b;

  logic ov3, os3, busy3, ov9, os9, busy9, ovt, ost, busyt, ov1, os1, busy1;
  logic signed [23:0] od3, od9, odt, od1;

  int passed = 0;
  int total  = 0;
  int pulses3 = 0;
  int n, p0;

  always #5 clk = ~clk;

  conv_mac_pipe #(.NUM_STAGE(3), .TAPS(3), .SHIFT(0), .SAT(1)) u_basic (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(v3), .in_a(in_a), .in_b(in_b),
    .restart(restart), .out_valid(ov3), .out_data(od3), .out_sat(os3), .busy(busy3));

  conv_mac_pipe #(.NUM_STAGE(3), .TAPS(9), .SHIFT(0), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(v9), .in_a(in_a), .in_b(in_b),
    .restart(restart), .out_valid(ov9), .out_data(od9), .out_sat(os9), .busy(busy9));

  conv_mac_pipe #(.NUM_STAGE(3), .TAPS(9), .SHIFT(0), .SAT(0)) u_trunc (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(v9), .in_a(in_a), .in_b(in_b),
    .restart(restart), .out_valid(ovt), .out_data(odt), .out_sat(ost), .busy(busyt));

  conv_mac_pipe #(.NUM_STAGE(3), .TAPS(1), .SHIFT(2), .SAT(1)) u_rnd (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(v1), .in_a(in_a), .in_b(in_b),
    .restart(restart), .out_valid(ov1), .out_data(od1), .out_sat(os1), .busy(busy1));

  // A result pulse is consumed by exactly one ce-high edge.
  always @(posedge clk) if (ce && ov3) pulses3++;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tap3(input int a, input int b);
    in_a = 16'(a); in_b = 8'(b); v3 = 1'b1;
    step();
    v3 = 1'b0;
  endtask

  function automatic logic ov_of(input int sel);
    case (sel)
      0:       return ov3;
      1:       return ov9;
      default: return ov1;
    endcase
  endfunction

  // Count edges until the selected out_valid rises (bounded).
  task automatic wait_ov(input int sel, output int cnt);
    cnt = 0;
    while (!ov_of(sel) && cnt < 50) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; restart = 1'b0;
    v3 = 1'b0; v9 = 1'b0; v1 = 1'b0; in_a = '0; in_b = '0;
    repeat (3) step();

    // Reset state
    chk("rst_ov", ov3, 0);
    chk("rst_od", od3, 0);
    chk("rst_os", os3, 0);
    chk("rst_busy", busy3 | busy9 | busyt | busy1, 0);
    chk("rst_ov_other", ov9 | ovt | ov1, 0);
    reset = 1'b0;
    step();

    // Basic window: 200 - 600 - 300 = -700, latency 5
    tap3(100, 2);
    chk("busy_mid", busy3, 1);
    tap3(-200, 3);
    tap3(300, -1);
    wait_ov(0, n);
    chk("basic_lat", n, 5);
    chk("basic_data", od3, -700);
    chk("basic_sat", os3, 0);
    step();
    chk("basic_pulse", ov3, 0);
    chk("basic_hold", od3, -700);

    // Stall mid-window (junk ignored) and mid-pipeline (4 cycles)
    tap3(100, 2);
    tap3(-200, 3);
    ce = 1'b0; v3 = 1'b1; in_a = 16'sd999; in_b = 8'sd9; restart = 1'b1;
    step(); step();
    restart = 1'b0; v3 = 1'b0; ce = 1'b1;
    tap3(300, -1);
    step();
    ce = 1'b0;
    repeat (4) step();
    chk("stall_no_early", ov3, 0);
    ce = 1'b1;
    wait_ov(0, n);
    chk("stall_lat_rest", n, 4);
    chk("stall_data", od3, -700);
    ce = 1'b0;
    step(); step();
    chk("stall_ov_held", ov3, 1);
    chk("stall_od_held", od3, -700);
    ce = 1'b1;
    step();
    chk("stall_ov_drop", ov3, 0);

    // Restart with a tap in the same cycle: 100 + 1 + 1 = 102
    p0 = pulses3;
    tap3(5, 5);
    tap3(6, 6);
    restart = 1'b1;
    tap3(10, 10);
    restart = 1'b0;
    tap3(1, 1);
    tap3(1, 1);
    wait_ov(0, n);
    chk("restart_lat", n, 5);
    chk("restart_data", od3, 102);
    repeat (10) step();
    chk("restart_one_pulse", pulses3 - p0, 1);
    chk("idle_busy", busy3, 0);

    // Reset with products in flight
    tap3(7, 7);
    tap3(8, 8);
    chk("pre_rst_busy", busy3, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_od", od3, 0);
    chk("async_rst_ov", ov3, 0);
    chk("async_rst_busy", busy3, 0);
    step();
    reset = 1'b0;
    step();
    tap3(1, 1);
    tap3(1, 1);
    tap3(1, 1);
    wait_ov(0, n);
    chk("post_rst_lat", n, 5);
    chk("post_rst_data", od3, 3);

    // Saturation vs truncation: 9 x 4194304 = 37748736
    in_a = -16'sd32768; in_b = -8'sd128; v9 = 1'b1;
    repeat (9) step();
    v9 = 1'b0;
    wait_ov(1, n);
    chk("sat_lat", n, 5);
    chk("sat_data", od9, 8388607);
    chk("sat_flag", os9, 1);
    chk("trunc_ov", ovt, 1);
    chk("trunc_data", odt, 4194304);
    chk("trunc_flag", ost, 0);

    // Rounding, SHIFT=2, back-to-back single-tap windows
    v1 = 1'b1;
    in_a = 16'sd3;  in_b = 8'sd2; step();
    in_a = -16'sd3; in_b = 8'sd2; step();
    in_a = 16'sd5;  in_b = 8'sd1; step();
    in_a = -16'sd5; in_b = 8'sd1; step();
    v1 = 1'b0;
    step();
    chk("rnd_early", ov1, 0);
    step();
    chk("rnd0_ov", ov1, 1);
    chk("rnd0", od1, 2);
    step();
    chk("rnd1_ov", ov1, 1);
    chk("rnd1", od1, -1);
    step();
    chk("rnd2", od1, 1);
    step();
    chk("rnd3", od1, -1);
    chk("rnd3_sat", os1, 0);
    step();
    chk("rnd_end", ov1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
